// File: rtl/interrupt_sequencer.sv
// Interrupt entry sequencer: priority-arbitrates masked flags, then pushes PC,
// loads the vector, clears the serviced flag and SREG I.
module interrupt_sequencer #(
    parameter int unsigned NUM_SRC    = 8,
    parameter logic [13:0] VEC_BASE   = 14'h002,
    parameter int unsigned VEC_STRIDE = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_flag,
    input  logic [NUM_SRC-1:0] irq_mask,
    input  logic               global_ie,
    input  logic               instr_boundary,
    input  logic               reti_done,
    input  logic               mem_ready,
    output logic               core_hold,
    output logic               push_pcl,
    output logic               push_pch,
    output logic               pc_load,
    output logic [13:0]        vector_addr,
    output logic [NUM_SRC-1:0] flag_clear,
    output logic               clear_i,
    output logic               in_service
);

    localparam int unsigned IDXW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PUSH_L,
        S_PUSH_H,
        S_VECTOR
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [IDXW-1:0]   r_idx;
    logic [13:0]       r_vec;
    logic              r_skip_one;
    logic              r_in_service;
    logic [NUM_SRC-1:0] w_pending;
    logic [IDXW-1:0]   w_win_idx;
    logic              w_enter;

    assign w_pending = irq_flag & irq_mask;

    // Scan from the top so the lowest set index is the final assignment.
    always_comb begin
        w_win_idx = '0;
        for (int unsigned i = NUM_SRC; i > 0; i--) begin
            if (w_pending[i-1]) w_win_idx = IDXW'(i - 1);
        end
    end

    // A RETI boundary never admits an entry, even before skip_one is visible.
    assign w_enter = (r_state == S_IDLE) & instr_boundary & global_ie &
                     (|w_pending) & ~r_skip_one & ~reti_done;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_enter)   w_next = S_PUSH_L;
            S_PUSH_L: if (mem_ready) w_next = S_PUSH_H;
            S_PUSH_H: if (mem_ready) w_next = S_VECTOR;
            S_VECTOR:                w_next = S_IDLE;
            default:                 w_next = S_IDLE;
        endcase
    end

    always_comb begin
        core_hold  = 1'b0;
        push_pcl   = 1'b0;
        push_pch   = 1'b0;
        pc_load    = 1'b0;
        clear_i    = 1'b0;
        flag_clear = '0;
        case (r_state)
            S_PUSH_L: begin
                core_hold = 1'b1;
                push_pcl  = 1'b1;
            end
            S_PUSH_H: begin
                core_hold = 1'b1;
                push_pch  = 1'b1;
            end
            S_VECTOR: begin
                core_hold  = 1'b1;
                pc_load    = 1'b1;
                clear_i    = 1'b1;
                flag_clear = NUM_SRC'(1) << r_idx;
            end
            default: ;
        endcase
    end

    assign vector_addr = r_vec;
    assign in_service  = r_in_service;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx        <= '0;
            r_vec        <= '0;
            r_skip_one   <= 1'b0;
            r_in_service <= 1'b0;
        end else begin
            if (w_enter) r_idx <= w_win_idx;
            // Vector is captured on entry to VECTOR and then held until the next one.
            if (r_state == S_PUSH_H && mem_ready)
                r_vec <= VEC_BASE + 14'(VEC_STRIDE * 32'(r_idx));
            if (reti_done)           r_skip_one <= 1'b1;
            else if (instr_boundary) r_skip_one <= 1'b0;
            if (r_state == S_VECTOR) r_in_service <= 1'b1;
            else if (reti_done)      r_in_service <= 1'b0;
        end
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: entry timing, priority, stalls,
// global enable, RETI skip rule and reset abort.
module tb_interrupt_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  irq_flag;
    logic [7:0]  irq_mask;
    logic        global_ie;
    logic        instr_boundary;
    logic        reti_done;
    logic        mem_ready;
    logic        core_hold;
    logic        push_pcl;
    logic        push_pch;
    logic        pc_load;
    logic [13:0] vector_addr;
    logic [7:0]  flag_clear;
    logic        clear_i;
    logic        in_service;

    int n_tests = 0;
    int n_fail  = 0;

    // {core_hold, push_pcl, push_pch, pc_load, clear_i, in_service}
    logic [5:0] ctl;
    assign ctl = {core_hold, push_pcl, push_pch, pc_load, clear_i, in_service};

    interrupt_sequencer #(
        .NUM_SRC(8),
        .VEC_BASE(14'h002),
        .VEC_STRIDE(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .irq_flag(irq_flag),
        .irq_mask(irq_mask),
        .global_ie(global_ie),
        .instr_boundary(instr_boundary),
        .reti_done(reti_done),
        .mem_ready(mem_ready),
        .core_hold(core_hold),
        .push_pcl(push_pcl),
        .push_pch(push_pch),
        .pc_load(pc_load),
        .vector_addr(vector_addr),
        .flag_clear(flag_clear),
        .clear_i(clear_i),
        .in_service(in_service)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        irq_flag = '0; irq_mask = '0; global_ie = 1'b0;
        instr_boundary = 1'b0; reti_done = 1'b0; mem_ready = 1'b1;
        tick; tick;
        reset = 1'b0;
        n_tests++;
        if (ctl !== 6'b000000) begin
            n_fail++; $display("FAIL reset_ctl: got %b expected %b", ctl, 6'b000000);
        end
        n_tests++;
        if (vector_addr !== 14'h0 || flag_clear !== 8'h00) begin
            n_fail++; $display("FAIL reset_vec: got vec=%h fc=%h expected vec=0000 fc=00", vector_addr, flag_clear);
        end
    endtask

    task automatic test_basic;
        irq_flag = 8'h10; irq_mask = 8'h10; global_ie = 1'b1;
        mem_ready = 1'b1; instr_boundary = 1'b1;
        tick;
        instr_boundary = 1'b0;
        n_tests++;
        if (ctl !== 6'b110000) begin
            n_fail++; $display("FAIL basic_pushl: got %b expected %b", ctl, 6'b110000);
        end
        tick;
        n_tests++;
        if (ctl !== 6'b101000) begin
            n_fail++; $display("FAIL basic_pushh: got %b expected %b", ctl, 6'b101000);
        end
        tick;
        n_tests++;
        if (ctl !== 6'b100110 || vector_addr !== 14'h00A || flag_clear !== 8'h10) begin
            n_fail++; $display("FAIL basic_vector: got ctl=%b vec=%h fc=%h expected ctl=100110 vec=000a fc=10", ctl, vector_addr, flag_clear);
        end
        irq_flag = 8'h00;
        tick;
        n_tests++;
        if (ctl !== 6'b000001 || vector_addr !== 14'h00A || flag_clear !== 8'h00) begin
            n_fail++; $display("FAIL basic_after: got ctl=%b vec=%h fc=%h expected ctl=000001 vec=000a fc=00", ctl, vector_addr, flag_clear);
        end
    endtask

    // Boundary stays high throughout; it must be ignored outside IDLE.
    task automatic test_priority;
        irq_flag = 8'h12; irq_mask = 8'hFF; instr_boundary = 1'b1;
        tick;
        n_tests++;
        if (ctl !== 6'b110001) begin
            n_fail++; $display("FAIL prio_pushl: got %b expected %b", ctl, 6'b110001);
        end
        tick;
        n_tests++;
        if (ctl !== 6'b101001) begin
            n_fail++; $display("FAIL prio_pushh: got %b expected %b", ctl, 6'b101001);
        end
        tick;
        n_tests++;
        if (ctl !== 6'b100111 || vector_addr !== 14'h004 || flag_clear !== 8'h02) begin
            n_fail++; $display("FAIL prio_vector: got ctl=%b vec=%h fc=%h expected ctl=100111 vec=0004 fc=02", ctl, vector_addr, flag_clear);
        end
        irq_flag = 8'h10;
        tick;
        n_tests++;
        if (ctl !== 6'b000001 || vector_addr !== 14'h004) begin
            n_fail++; $display("FAIL prio_idle: got ctl=%b vec=%h expected ctl=000001 vec=0004", ctl, vector_addr);
        end
        tick;
        instr_boundary = 1'b0;
        n_tests++;
        if (ctl !== 6'b110001) begin
            n_fail++; $display("FAIL prio2_pushl: got %b expected %b", ctl, 6'b110001);
        end
        tick; tick;
        n_tests++;
        if (ctl !== 6'b100111 || vector_addr !== 14'h00A || flag_clear !== 8'h10) begin
            n_fail++; $display("FAIL prio2_vector: got ctl=%b vec=%h fc=%h expected ctl=100111 vec=000a fc=10", ctl, vector_addr, flag_clear);
        end
        irq_flag = 8'h00;
        tick;
    endtask

    task automatic test_stall;
        irq_flag = 8'h01; irq_mask = 8'hFF; instr_boundary = 1'b1; mem_ready = 1'b0;
        tick;
        instr_boundary = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) mem_ready = 1'b1;
            n_tests++;
            if (ctl !== 6'b110001) begin
                n_fail++; $display("FAIL stall_pushl%0d: got %b expected %b", i, ctl, 6'b110001);
            end
            tick;
        end
        n_tests++;
        if (ctl !== 6'b101001) begin
            n_fail++; $display("FAIL stall_pushh: got %b expected %b", ctl, 6'b101001);
        end
        tick;
        n_tests++;
        if (ctl !== 6'b100111 || vector_addr !== 14'h002 || flag_clear !== 8'h01) begin
            n_fail++; $display("FAIL stall_vector: got ctl=%b vec=%h fc=%h expected ctl=100111 vec=0002 fc=01", ctl, vector_addr, flag_clear);
        end
        irq_flag = 8'h00;
        tick;
        n_tests++;
        if (ctl !== 6'b000001) begin
            n_fail++; $display("FAIL stall_after: got %b expected %b", ctl, 6'b000001);
        end
    endtask

    task automatic test_global_ie;
        global_ie = 1'b0; irq_flag = 8'h08; irq_mask = 8'hFF; instr_boundary = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            n_tests++;
            if (ctl !== 6'b000001) begin
                n_fail++; $display("FAIL gie_blocked%0d: got %b expected %b", i, ctl, 6'b000001);
            end
        end
        global_ie = 1'b1;
        tick;
        instr_boundary = 1'b0;
        n_tests++;
        if (ctl !== 6'b110001) begin
            n_fail++; $display("FAIL gie_pushl: got %b expected %b", ctl, 6'b110001);
        end
        tick; tick;
        n_tests++;
        if (ctl !== 6'b100111 || vector_addr !== 14'h008 || flag_clear !== 8'h08) begin
            n_fail++; $display("FAIL gie_vector: got ctl=%b vec=%h fc=%h expected ctl=100111 vec=0008 fc=08", ctl, vector_addr, flag_clear);
        end
        irq_flag = 8'h00;
        tick;
    endtask

    task automatic test_reti_skip;
        irq_flag = 8'h04; irq_mask = 8'hFF; instr_boundary = 1'b1; reti_done = 1'b1;
        tick;
        reti_done = 1'b0;
        n_tests++;
        if (ctl !== 6'b000000) begin
            n_fail++; $display("FAIL reti_cycle: got %b expected %b", ctl, 6'b000000);
        end
        tick;
        n_tests++;
        if (ctl !== 6'b000000) begin
            n_fail++; $display("FAIL reti_skip: got %b expected %b", ctl, 6'b000000);
        end
        tick;
        instr_boundary = 1'b0;
        n_tests++;
        if (ctl !== 6'b110000) begin
            n_fail++; $display("FAIL reti_entry: got %b expected %b", ctl, 6'b110000);
        end
        tick; tick;
        n_tests++;
        if (ctl !== 6'b100110 || vector_addr !== 14'h006 || flag_clear !== 8'h04) begin
            n_fail++; $display("FAIL reti_vector: got ctl=%b vec=%h fc=%h expected ctl=100110 vec=0006 fc=04", ctl, vector_addr, flag_clear);
        end
        irq_flag = 8'h00;
        tick;
    endtask

    task automatic test_reset_abort;
        irq_flag = 8'h20; irq_mask = 8'hFF; instr_boundary = 1'b1;
        tick;
        instr_boundary = 1'b0;
        tick;
        n_tests++;
        if (ctl !== 6'b101001) begin
            n_fail++; $display("FAIL abort_pushh: got %b expected %b", ctl, 6'b101001);
        end
        reset = 1'b1;
        tick;
        reset = 1'b0; global_ie = 1'b0;
        n_tests++;
        if (ctl !== 6'b000000 || vector_addr !== 14'h0 || flag_clear !== 8'h00) begin
            n_fail++; $display("FAIL abort_reset: got ctl=%b vec=%h fc=%h expected ctl=000000 vec=0000 fc=00", ctl, vector_addr, flag_clear);
        end
        for (int i = 0; i < 3; i++) begin
            tick;
            n_tests++;
            if (pc_load !== 1'b0 || flag_clear !== 8'h00 || core_hold !== 1'b0) begin
                n_fail++; $display("FAIL abort_quiet%0d: got pc_load=%b fc=%h hold=%b expected 0 00 0", i, pc_load, flag_clear, core_hold);
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_priority;
        test_stall;
        test_global_ie;
        test_reti_skip;
        test_reset_abort;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Arbitrates pending peripheral interrupt flags (timer compare/overflow) against their mask bits and the SREG I bit.
- At an instruction boundary, takes over the core and sequences the entry: push PCL, push PCH, load the vector into the PC, clear the serviced flag and the I bit.
- Sits between the timers/TIFR/TIMSK, the control unit, the stack-pointer/memory-map path and the program-counter load mux.
- Enforces the AVR rule that one instruction executes after RETI before another interrupt is taken.

Parameters:
- NUM_SRC, 8: number of interrupt sources. Index 0 has the highest priority.
- VEC_BASE, 14'h002: program-memory word address of the source-0 vector.
- VEC_STRIDE, 2: words between consecutive vectors.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- irq_flag  input  NUM_SRC  raw interrupt flags (TIFR-derived)
- irq_mask  input  NUM_SRC  enable bits (TIMSK-derived)
- global_ie  input  1  SREG I bit
- instr_boundary  input  1  control unit: the current instruction completes this cycle
- reti_done  input  1  single-cycle pulse on the RETI completion cycle
- mem_ready  input  1  stack write accepted this cycle
- core_hold  output  1  stall fetch/PC increment while sequencing
- push_pcl  output  1  write PC[7:0] to SP, decrement SP
- push_pch  output  1  write {2'b0,PC[13:8]} to SP, decrement SP
- pc_load  output  1  overwrite PC with vector_addr
- vector_addr  output  14  vector of the latched source
- flag_clear  output  NUM_SRC  one-hot pulse clearing the serviced flag
- clear_i  output  1  pulse clearing SREG I
- in_service  output  1  set on entry, cleared by reti_done

Behaviour:
- Reset: state IDLE. All outputs 0, vector_addr 14'h0. The latched index, skip_one and in_service are cleared. Reset asserted mid-sequence aborts to IDLE with no further strobes.
- pending = irq_flag & irq_mask. The winner is the lowest set index (combinational priority encoder).
- States: IDLE, PUSH_L, PUSH_H, VECTOR.
- IDLE to PUSH_L: requires instr_boundary & global_ie & |pending & !skip_one. The winner index is latched on this edge. core_hold rises in the next cycle.
- PUSH_L: push_pcl=1, core_hold=1.
  - mem_ready=1: go to PUSH_H.
  - mem_ready=0: stay, with strobe held.
- PUSH_H: push_pch=1, core_hold=1. Same mem_ready stall rule; on ready, go to VECTOR.
- VECTOR (exactly 1 cycle): pc_load=1, clear_i=1, flag_clear[idx]=1, core_hold=1.
  - vector_addr = VEC_BASE + VEC_STRIDE*idx, truncated to 14 bits.
  - Next state IDLE. in_service is set on the following edge.
- vector_addr is held after VECTOR until the next entry.
- Minimum entry latency: 3 cycles from the accepting boundary (PUSH_L, PUSH_H, VECTOR), plus one cycle per mem_ready stall.
- The latched index is fixed for the whole sequence. If the flag drops, or a higher-priority flag rises, after latching, the original source is still serviced and only its flag is cleared.
- skip_one:
  - Set by reti_done. Cleared by the next instr_boundary that is not in the same cycle as reti_done.
  - While set, entry is blocked.
  - reti_done coincident with instr_boundary counts as the RETI's own boundary: no entry that cycle, and skip_one stays set.
- in_service: cleared by reti_done. Set has priority if both occur on the same edge.
- global_ie=0 or mask=0: flags remain pending with no entry. Entry occurs at the first boundary after enabling.
- Only one strobe among push_pcl/push_pch/pc_load is active in any cycle.
- Entry is decided only in IDLE. instr_boundary in other states is ignored.

Test Plan:
- Reset, then irq_flag=8'h10, irq_mask=8'h10, global_ie=1, boundary pulse, mem_ready=1 -> the next 3 cycles show push_pcl, push_pch, then pc_load. vector_addr=14'h00A, flag_clear=8'h10, clear_i=1. in_service=1 after.
- irq_flag=8'h12, mask=8'hFF -> index 1 wins: vector_addr=14'h004, flag_clear=8'h02. Index 4 remains pending and is taken at the next eligible boundary.
- mem_ready=0 for 2 cycles in PUSH_L -> push_pcl is held 3 cycles. pc_load occurs 5 cycles after the boundary. No double push.
- global_ie=0 with flag pending over 4 boundaries -> no strobes. Set global_ie=1 -> entry at the next boundary.
- reti_done with flag pending and boundaries every cycle -> no entry at the RETI cycle, nor at the next boundary. push_pcl appears after the second boundary. in_service is 0 after reti_done.
- Assert reset during PUSH_H -> all outputs 0 next cycle. No pc_load and no flag_clear ever issued for the aborted entry.
